// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch unit with redirect and drop handling
//
// Fetches 32-bit instruction words from PC. At most one request is outstanding.
// The fetched word and its PC are held for decode until decode consumes them.
// A branch redirect reloads PC. If a request is still in flight, its response
// is marked to be dropped.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/addr/ready       fetch request handshake (addr = PC)
//   imem_rsp_valid/data             returned instruction word
//   instr_valid/ready, instruction  held instruction handshake to decode
//   Opcode                          instruction[6:0] of the held word
//   pc_out                          PC of the held instruction
//   branch_taken/target             one-cycle redirect strobe and address
//   fetch_err                       sticky misaligned-redirect error
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a misaligned redirect target traps into ERR (exit only by reset)
//   undefined - the low two bits of the redirect target are cleared; fetch_err is 0

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [6:0]  Opcode,
  output logic [31:0] pc_out,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] pc_hold;
  logic        drop;
  logic        misalign;
  logic [31:0] redirect_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_q;
  assign misalign    = (branch_target[1:0] != 2'b00);
  assign redirect_pc = branch_target;
  assign fetch_err   = err_q;
`else
  assign misalign    = 1'b0;
  assign redirect_pc = branch_target & 32'hFFFF_FFFC;
  assign fetch_err   = 1'b0;
`endif

  // Request and valid flags are decoded from state so that they drop
  // immediately when reset asserts.
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == S_HOLD);
  assign instruction    = instr_q;
  assign Opcode         = instr_q[6:0];
  assign pc_out         = pc_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      instr_q <= 32'h0000_0000;
      pc_hold <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else if (branch_taken && state != S_ERR) begin
      if (misalign) begin
        state <= S_ERR;
        drop  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        err_q <= 1'b1;
`endif
      end else begin
        pc <= redirect_pc;
        case (state)
          S_REQ: begin
            // The request accepted this cycle carries the old PC. Its
            // response must be dropped.
            if (imem_req_ready) begin
              state <= S_WAIT;
              drop  <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
          S_WAIT: begin
            // A response arriving with the redirect is discarded here. No
            // request is left in flight, so refetch immediately rather
            // than wait for a response that will not come.
            if (imem_rsp_valid) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              state <= S_WAIT;
              drop  <= 1'b1;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              instr_q <= imem_rsp_data;
              pc_hold <= pc;
              state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_addr  output  32  fetch byte address (= PC).
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_rsp_valid  input  1  instruction word returned.
REQ-008 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-009 SHALL have port instr_valid  output  1  held instruction valid for decode.
REQ-010 SHALL have port instr_ready  input  1  decode consumes held instruction.
REQ-011 SHALL have port instruction  output  32  held instruction word to decode/immediate generation.
REQ-012 SHALL have port Opcode  output  7  instruction[6:0], combinational from held register.
REQ-013 SHALL have port pc_out  output  32  PC of held instruction.
REQ-014 SHALL have port branch_taken  input  1  redirect strobe, one cycle.
REQ-015 SHALL have port branch_target  input  32  redirect address.
REQ-016 SHALL have port fetch_err  output  1  sticky misaligned-redirect error (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, ERR.
REQ-018 IDLE: SHALL move to REQ one cycle after reset release; no request issued in IDLE.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=PC; on imem_req_ready=1 SHALL move to WAIT.
REQ-020 WAIT: on imem_rsp_valid=1 with drop flag clear SHALL capture imem_rsp_data and PC into hold registers, move to HOLD; instr_valid=1 from the next cycle.
REQ-021 WAIT: on imem_rsp_valid=1 with drop flag set SHALL discard data, clear drop flag, move to REQ.
REQ-022 HOLD: instruction/pc_out SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-023 HOLD: on instr_ready=1 SHALL set PC<=PC+4 (modulo 2^32, wrap from FFFF_FFFC to 0), deassert instr_valid, move to REQ.
REQ-024 Minimum latency: request accepted cycle N, response cycle N+1 earliest, instr_valid high cycle N+2.
REQ-025 branch_taken SHALL load PC<=branch_target and deassert instr_valid next cycle in any non-ERR state.
REQ-026 branch_taken in WAIT, or in REQ coinciding with imem_req_ready=1, SHALL set drop flag and go/stay WAIT.
REQ-027 branch_taken in IDLE, HOLD, or REQ without handshake SHALL go to REQ.
REQ-028 branch_taken SHALL take priority over simultaneous instr_ready=1 (no PC+4).
REQ-029 branch_taken coinciding with imem_rsp_valid in WAIT SHALL discard that response.
REQ-030 At most one request outstanding; imem_req_valid SHALL be 0 outside REQ.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, PC=RESET_PC, drop flag 0, instr_valid 0, instruction 0, pc_out 0, imem_req_valid 0, fetch_err 0.
REQ-032 Reset mid-transaction SHALL abandon outstanding request; responses arriving while in IDLE SHALL be ignored.

Configuration
REQ-033 Macro FETCH_MISALIGN_TRAP_EN defined: branch_taken with branch_target[1:0]!=0 SHALL set fetch_err=1, instr_valid=0, enter ERR; ERR issues no requests and exits only by reset.
REQ-034 Macro undefined: branch_target[1:0] SHALL be forced to 00 on load; fetch_err tied 0; ERR unreachable.

Verification
REQ-035 Reset release, ready=1, rsp one cycle after accept with data 0x00500093 -> req addr 0x0 at cycle 1, instr_valid cycle 3, Opcode=0x13, pc_out=0.
REQ-036 Hold instr_ready=0 ten cycles -> instruction and pc_out unchanged, imem_req_valid=0; then instr_ready=1 -> next req addr 0x4.
REQ-037 branch_taken target 0x100 while in WAIT, stale rsp 0xDEADBEEF arrives -> data discarded, next req addr 0x100, instr_valid only for the 0x100 response.
REQ-038 branch_taken 0x40 and instr_ready=1 same cycle in HOLD -> next req addr 0x40, not PC+4.
REQ-039 branch_target 0x102: with FETCH_MISALIGN_TRAP_EN -> fetch_err=1, no further requests; without -> req addr 0x100.
REQ-040 rst_n low asynchronously during WAIT -> outputs at reset values before next clock edge; after release first req addr RESET_PC.
